// File: rtl/econet_pkg.sv
// Shared constants for the Econet receive PHY: FSM state codes, flag
// pattern, stuffing threshold and closing-flag alignment residue.
package econet_pkg;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [7:0] FLAG                = 8'h7E;
   localparam logic [3:0] STUFF_ONES          = 4'd5;
   localparam logic [3:0] FLAG_RUN            = 4'($countones(FLAG));
   localparam logic [2:0] FRAME_ALIGN_RESIDUE = 3'd6;

   // Saturating 4-bit increment used by the ones counter.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'd1;
   endfunction

endpackage

// File: rtl/econet_rx_destuff.sv
// Econet receive front end: registers the line bit, tracks the run of
// consecutive ones and classifies each processed bit as data, stuffed
// zero, flag or abort. Also reports the line-idle level.
module econet_rx_destuff
   import econet_pkg::*;
#(
   parameter bit INVERT_INPUT = 1'b1,
   parameter int ABORT_ONES   = 7,
   parameter int IDLE_ONES    = 15
) (
   input  logic econet_clk,
   input  logic reset_n,
   input  logic econet_data,
   output logic data_bit,
   output logic data_valid,
   output logic flag_det,
   output logic abort_det,
   output logic line_idle
);

   localparam logic [3:0] ABORT_RUN = 4'(ABORT_ONES - 1);
   localparam logic [3:0] IDLE_RUN  = 4'(IDLE_ONES);

   logic       in_r;
   logic [3:0] onecount_r;
   logic       line_idle_r;
   logic [3:0] onecount_next_s;

   // Classify the registered bit against the ones run seen before it.
   always_comb begin
      onecount_next_s = 4'd0;
      data_bit        = in_r;
      data_valid      = 1'b0;
      flag_det        = 1'b0;
      abort_det       = 1'b0;
      if (in_r) begin
         onecount_next_s = sat_inc4(onecount_r);
         data_valid      = (onecount_r < STUFF_ONES);
         abort_det       = (onecount_r == ABORT_RUN);
      end else begin
         onecount_next_s = 4'd0;
         flag_det        = (onecount_r == FLAG_RUN);
         data_valid      = (onecount_r != STUFF_ONES) && (onecount_r != FLAG_RUN);
      end
   end

   // Input register, ones counter and idle level.
   always_ff @(posedge econet_clk) begin
      if (!reset_n) begin
         in_r        <= 1'b0;
         onecount_r  <= 4'd0;
         line_idle_r <= 1'b0;
      end else begin
         in_r        <= econet_data ^ INVERT_INPUT;
         onecount_r  <= onecount_next_s;
         line_idle_r <= (onecount_next_s >= IDLE_RUN);
      end
   end

   assign line_idle = line_idle_r;

endmodule

// File: rtl/econet_rx.sv
// Econet receive PHY top: frame FSM (hunt/sync/data), LSB-first byte
// assembly and the byte/frame strobes delivered to the frame layer.
module econet_rx
   import econet_pkg::*;
#(
   parameter bit INVERT_INPUT = 1'b1,
   parameter int ABORT_ONES   = 7,
   parameter int IDLE_ONES    = 15
) (
   input  logic       econet_clk,
   input  logic       reset_n,
   input  logic       econet_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_error,
   output logic       frame_abort,
   output logic       receiving,
   output logic       line_idle
);

   localparam logic [2:0] BIT_LAST = 3'd7;

   logic       data_bit_s;
   logic       data_valid_s;
   logic       flag_det_s;
   logic       abort_det_s;

   logic [1:0] state_r;
   logic [6:0] shreg_r;
   logic [2:0] bitcount_r;
   logic [7:0] rx_byte_r;
   logic       byte_valid_r;
   logic       frame_start_r;
   logic       frame_end_r;
   logic       frame_error_r;
   logic       frame_abort_r;
   logic       receiving_r;

   econet_rx_destuff #(
      .INVERT_INPUT (INVERT_INPUT),
      .ABORT_ONES   (ABORT_ONES),
      .IDLE_ONES    (IDLE_ONES)
   ) u_destuff (
      .econet_clk  (econet_clk),
      .reset_n     (reset_n),
      .econet_data (econet_data),
      .data_bit    (data_bit_s),
      .data_valid  (data_valid_s),
      .flag_det    (flag_det_s),
      .abort_det   (abort_det_s),
      .line_idle   (line_idle)
   );

   // Frame FSM, byte assembly and registered strobes.
   always_ff @(posedge econet_clk) begin
      if (!reset_n) begin
         state_r       <= ST_HUNT;
         shreg_r       <= 7'd0;
         bitcount_r    <= 3'd0;
         rx_byte_r     <= 8'd0;
         byte_valid_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_end_r   <= 1'b0;
         frame_error_r <= 1'b0;
         frame_abort_r <= 1'b0;
         receiving_r   <= 1'b0;
      end else begin
         byte_valid_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_end_r   <= 1'b0;
         frame_error_r <= 1'b0;
         frame_abort_r <= 1'b0;
         case (state_r)
            ST_HUNT: begin
               if (flag_det_s) begin
                  state_r    <= ST_SYNC;
                  bitcount_r <= 3'd0;
               end
            end
            ST_SYNC, ST_DATA: begin
               if (abort_det_s) begin
                  // Abort discards any partial byte; only a live frame reports it.
                  frame_abort_r <= (state_r == ST_DATA);
                  receiving_r   <= 1'b0;
                  state_r       <= ST_HUNT;
                  bitcount_r    <= 3'd0;
               end else if (flag_det_s) begin
                  // An aligned closing flag leaves exactly its 0 and five 1s assembled.
                  frame_end_r   <= (state_r == ST_DATA);
                  frame_error_r <= (bitcount_r != FRAME_ALIGN_RESIDUE);
                  receiving_r   <= 1'b0;
                  state_r       <= ST_SYNC;
                  bitcount_r    <= 3'd0;
               end else if (data_valid_s) begin
                  shreg_r    <= {data_bit_s, shreg_r[6:1]};
                  bitcount_r <= bitcount_r + 3'd1;
                  if (bitcount_r == BIT_LAST) begin
                     rx_byte_r    <= {data_bit_s, shreg_r};
                     byte_valid_r <= 1'b1;
                     if (state_r == ST_SYNC) begin
                        frame_start_r <= 1'b1;
                        receiving_r   <= 1'b1;
                        state_r       <= ST_DATA;
                     end
                  end
               end
            end
            default: begin
               state_r    <= ST_HUNT;
               bitcount_r <= 3'd0;
            end
         endcase
      end
   end

   assign rx_byte     = rx_byte_r;
   assign byte_valid  = byte_valid_r;
   assign frame_start = frame_start_r;
   assign frame_end   = frame_end_r;
   assign frame_error = frame_error_r;
   assign frame_abort = frame_abort_r;
   assign receiving   = receiving_r;

endmodule

// File: tb/tb_econet_rx.sv
// Self-checking bench for econet_rx. A line-level stream is built from
// HDLC-style primitives (flags, stuffed bytes, raw ones, resets); for
// every line bit the bench derives the expected strobes/levels from the
// Econet framing rules and compares them two clocks after the bit.
module tb_econet_rx;

   localparam bit INV        = 1'b1;
   localparam int ABORT_ONES = 7;
   localparam int IDLE_ONES  = 15;

   logic       econet_clk = 1'b0;
   logic       reset_n    = 1'b0;
   logic       econet_data = 1'b1;
   logic [7:0] rx_byte;
   logic       byte_valid, frame_start, frame_end, frame_error;
   logic       frame_abort, receiving, line_idle;

   econet_rx #(
      .INVERT_INPUT (INV),
      .ABORT_ONES   (ABORT_ONES),
      .IDLE_ONES    (IDLE_ONES)
   ) dut (
      .econet_clk  (econet_clk),
      .reset_n     (reset_n),
      .econet_data (econet_data),
      .rx_byte     (rx_byte),
      .byte_valid  (byte_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frame_error (frame_error),
      .frame_abort (frame_abort),
      .receiving   (receiving),
      .line_idle   (line_idle)
   );

   always #5 econet_clk = ~econet_clk;

   typedef struct {
      bit       rst;
      bit       b;
      bit       bv;
      bit [7:0] byte_v;
      bit       fs;
      bit       fe;
      bit       ferr;
      bit       fa;
      bit       recv;
      bit       idle;
   } ent_t;

   ent_t stream_q[$];

   // Reference model: 0 = hunting, 1 = synced between frames, 2 = in frame.
   int       m_state = 0;
   int       m_run   = 0;
   int       m_k     = 0;
   bit [7:0] m_acc   = 8'd0;
   bit       m_recv  = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Append one line bit (data polarity) and its expected effect.
   task automatic push_raw(input bit b, input bit rst);
      ent_t e;
      int   run_before;
      bit   is_flag, is_abort, is_data;
      e = '{default: 0};
      e.rst = rst;
      e.b   = b;
      run_before = m_run;
      is_flag  = (b == 1'b0) && (run_before == 6);
      is_abort = (b == 1'b1) && (run_before == ABORT_ONES - 1);
      is_data  = b ? (run_before < 5) : (run_before != 5 && run_before != 6);
      m_run    = b ? m_run + 1 : 0;
      if (is_data && m_state != 0) begin
         m_acc[m_k] = b;
         m_k++;
         if (m_k == 8) begin
            e.bv     = 1'b1;
            e.byte_v = m_acc;
            if (m_state == 1) begin
               e.fs    = 1'b1;
               m_state = 2;
               m_recv  = 1'b1;
            end
            m_k = 0;
         end
      end
      if (is_abort) begin
         if (m_state == 2) e.fa = 1'b1;
         if (m_state != 0) begin
            m_state = 0;
            m_recv  = 1'b0;
         end
      end else if (is_flag) begin
         if (m_state != 0) begin
            e.fe   = (m_state == 2);
            e.ferr = (m_k != 6);
         end
         m_state = 1;
         m_recv  = 1'b0;
         m_k     = 0;
      end
      e.recv = m_recv;
      e.idle = (m_run >= IDLE_ONES);
      stream_q.push_back(e);
   endtask

   task automatic add_reset();
      m_state = 0;
      m_run   = 0;
      m_k     = 0;
      m_recv  = 1'b0;
      push_raw(1'b0, 1'b1);
   endtask

   task automatic send_data_bit(input bit b);
      push_raw(b, 1'b0);
      if (b && m_run == 5) push_raw(1'b0, 1'b0);
   endtask

   task automatic send_byte(input bit [7:0] v);
      for (int i = 0; i < 8; i++) send_data_bit(v[i]);
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) send_data_bit(1'($urandom_range(0, 1)));
   endtask

   task automatic send_flag();
      push_raw(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) push_raw(1'b1, 1'b0);
      push_raw(1'b0, 1'b0);
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) push_raw(1'b1, 1'b0);
   endtask

   task automatic check_entry(input ent_t e);
      chk("byte_valid", byte_valid, e.bv);
      if (e.bv) chk("rx_byte", rx_byte, e.byte_v);
      chk("frame_start", frame_start, e.fs);
      chk("frame_end", frame_end, e.fe);
      chk("frame_error", frame_error, e.ferr);
      chk("frame_abort", frame_abort, e.fa);
      chk("receiving", receiving, e.recv);
      chk("line_idle", line_idle, e.idle);
   endtask

   task automatic check_reset();
      chk("rst_rx_byte", rx_byte, 8'd0);
      chk("rst_byte_valid", byte_valid, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_frame_end", frame_end, 1'b0);
      chk("rst_frame_error", frame_error, 1'b0);
      chk("rst_frame_abort", frame_abort, 1'b0);
      chk("rst_receiving", receiving, 1'b0);
      chk("rst_line_idle", line_idle, 1'b0);
   endtask

   initial begin
      int nb;
      // Build the stream: directed scenarios first.
      add_reset();
      send_ones(20); send_flag(); send_byte(8'hA5); send_flag();
      send_flag(); send_byte(8'hFF); send_flag();
      send_flag(); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h00); send_flag();
      send_flag(); send_byte(8'h12); send_ones(7); send_byte(8'h34); send_ones(3);
      send_flag(); send_byte(8'h55); send_bits(3); send_flag();
      send_flag(); send_byte(8'h3C); send_bits(5);
      add_reset();
      send_ones(16);
      // Randomized frames, aborts, idle runs and resets.
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 4) == 0) send_ones($urandom_range(7, 20));
         if ($urandom_range(0, 29) == 0) add_reset();
         send_flag();
         nb = $urandom_range(0, 5);
         for (int j = 0; j < nb; j++) send_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) send_bits($urandom_range(1, 7));
         if ($urandom_range(0, 4) == 0) begin
            send_ones($urandom_range(7, 10));
            send_bits($urandom_range(0, 12));
         end
      end
      send_flag();
      send_ones(4);

      // Drive the stream; outputs after edge i reflect bit i-1.
      reset_n     = 1'b0;
      econet_data = 1'b1;
      repeat (2) @(posedge econet_clk);
      #1;
      for (int i = 0; i <= stream_q.size(); i++) begin
         if (i < stream_q.size()) begin
            reset_n     = stream_q[i].rst ? 1'b0 : 1'b1;
            econet_data = stream_q[i].b ^ INV;
         end else begin
            reset_n     = 1'b1;
            econet_data = 1'b1 ^ INV;
         end
         @(posedge econet_clk);
         #1;
         if (i < stream_q.size() && stream_q[i].rst) check_reset();
         else if (i >= 1) check_entry(stream_q[i-1]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/econet_rx.md
Name: econet_rx

Overview:
Receive-side Econet bit-level PHY. Samples the serial line on econet_clk, hunts for HDLC flags (01111110), removes stuffed zeros, and assembles bytes LSB-first. Delivers bytes with single-cycle strobes plus frame start, end, error and abort indications. Sits between the line receiver pin and the frame/packet layer; it is the counterpart of the Econet transmit PHY. CRC checking is done by the frame layer, not in this block.

Parameters:
INVERT_INPUT, 1, 1 = line is inverted (data bit = ~econet_data); 0 = pass-through
ABORT_ONES, 7, consecutive ones that signal abort (7..14)
IDLE_ONES, 15, consecutive ones that signal line idle (ABORT_ONES+1..15)

Ports:
econet_clk  input  1  Econet bit clock; all logic on its rising edge
reset_n  input  1  synchronous, active-low reset
econet_data  input  1  serial line data
rx_byte  output  8  received byte; valid only while byte_valid=1
byte_valid  output  1  one-cycle strobe, one per received byte
frame_start  output  1  one-cycle pulse, coincident with the first byte_valid of a frame
frame_end  output  1  one-cycle pulse when the closing flag is seen
frame_error  output  1  one-cycle pulse when the closing flag is not byte-aligned
frame_abort  output  1  one-cycle pulse when ABORT_ONES ones are seen inside a frame
receiving  output  1  level; high from the first byte of a frame until end, abort or error
line_idle  output  1  level; high after IDLE_ONES consecutive ones, cleared by any 0

Behaviour:
- Reset: reset_n=0 at a rising edge clears all outputs (rx_byte=0), counters and the input register, and sets state=HUNT. Reset mid-frame gives no end, error or abort pulse.
- Input stage: bit d=econet_data^INVERT_INPUT is registered. A bit sampled at edge N is processed at edge N+1, and the resulting strobes are high for the cycle after edge N+1.
- onecount: 4 bits, saturates at 15, cleared by a 0. line_idle=1 when onecount>=IDLE_ONES.
- Destuff, evaluated per processed bit with onecount before update:
  - 0 with onecount==5: stuffed zero. Dropped; no data bit.
  - 0 with onecount==6: flag detected. Not a data bit.
  - 1 with onecount>=5: not a data bit.
  - onecount reaching ABORT_ONES: abort event, once per run of ones.
  - Any other bit is a data bit. It shifts into shreg at position bitcount (LSB first), and bitcount increments mod 8.
- bitcount: 3 bits. It wraps 7->0 on a data bit; when it wraps, rx_byte<=assembled byte and byte_valid pulses.
- States:
  - HUNT: data bits ignored, no strobes. Flag -> SYNC with bitcount=0.
  - SYNC: flag -> stays in SYNC, bitcount=0. First completed byte -> DATA, with byte_valid, frame_start and receiving=1. Abort -> HUNT, no pulse.
  - DATA: each completed byte gives byte_valid. Abort -> frame_abort, receiving=0, HUNT.
  - Flag in DATA with bitcount==6 (the flag's 0 plus five 1s were assembled): frame_end, receiving=0, SYNC, bitcount=0.
  - Flag in DATA with bitcount!=6: frame_end and frame_error in the same cycle, then SYNC.
- Flag in SYNC with bitcount!=6 (partial bits, zero bytes): frame_error alone, no frame_end; stays in SYNC.
- A closing flag also opens the next frame; shared-zero flags are not supported.
- Simultaneous events: byte completion and flag cannot coincide, because a flag bit is never a data bit. Abort takes precedence over a byte in progress; the partial byte is discarded.

Decomposition:
- Package econet_pkg: state encoding (HUNT, SYNC, DATA), FLAG=8'h7E, STUFF_ONES=5, FRAME_ALIGN_RESIDUE=3'd6.
- Sub-module econet_rx_destuff: input register, onecount, line_idle, and per-bit outputs data_bit, data_valid, flag_det and abort_det.
- econet_rx holds the FSM, shreg, bitcount and output strobes.

Test Plan:
1. Send idle 1s, flag, 0xA5 (1,0,1,0,0,1,0,1), flag -> one byte_valid with rx_byte=0xA5 plus frame_start; frame_end 2 cycles after the last flag bit; no frame_error.
2. Send flag, 0xFF sent as 11111 0 111, flag -> rx_byte=0xFF; the stuffed zero is removed.
3. Send flag, 0x01, 0x7E (stuffed), 0x00, flag -> three strobes 0x01, 0x7E, 0x00; frame_start only with 0x01.
4. Send flag, 0x12, then seven 1s -> byte 0x12 delivered, then frame_abort pulse with no frame_end, receiving=0; the next 0x34 without a flag is ignored.
5. Send flag, 0x55, 3 extra data bits, flag -> byte 0x55, then frame_end and frame_error in the same cycle.
6. Assert reset_n=0 for 1 cycle mid-byte, then 16 ones -> all outputs 0, no pulses, line_idle=1 after the 15th one.
